// File: rtl/id_ex_hazard_ctrl_if.sv
// id_ex_hazard_ctrl_if: decode/execute hazard signals; HAZ_STALL_CNT_EN adds the stall/flush counters
interface id_ex_hazard_ctrl_if;
  logic [4:0] i_ifid_rs, i_ifid_rt, i_idex_rt;
  logic i_ifid_uses_rt, i_idex_MemRead, i_mdu_start, i_branch_taken;
  logic o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_IDEX_bubble, o_IFID_flush;
  logic [1:0] o_state;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] o_stall_cycles;
  logic [15:0] o_flush_count;
  modport master (
    output i_ifid_rs, i_ifid_rt, i_idex_rt, i_ifid_uses_rt, i_idex_MemRead, i_mdu_start, i_branch_taken,
    input o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_IDEX_bubble, o_IFID_flush, o_state, o_stall_cycles, o_flush_count
  );
  modport slave (
    input i_ifid_rs, i_ifid_rt, i_idex_rt, i_ifid_uses_rt, i_idex_MemRead, i_mdu_start, i_branch_taken,
    output o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_IDEX_bubble, o_IFID_flush, o_state, o_stall_cycles, o_flush_count
  );
`else
  modport master (
    output i_ifid_rs, i_ifid_rt, i_idex_rt, i_ifid_uses_rt, i_idex_MemRead, i_mdu_start, i_branch_taken,
    input o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_IDEX_bubble, o_IFID_flush, o_state
  );
  modport slave (
    input i_ifid_rs, i_ifid_rt, i_idex_rt, i_ifid_uses_rt, i_idex_MemRead, i_mdu_start, i_branch_taken,
    output o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_IDEX_bubble, o_IFID_flush, o_state
  );
`endif
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: load-use / MDU stall and branch flush control for ID/EX; HAZ_STALL_CNT_EN adds counters
module id_ex_hazard_ctrl #(
  parameter int MDU_LATENCY = 4
) (
  input logic i_clk,
  input logic i_rst,
  id_ex_hazard_ctrl_if.slave h
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MDU_WAIT = 2'd2} state_t;
  localparam int CW = $clog2(MDU_LATENCY) + 1;
  localparam logic [CW-1:0] MDU_INIT = CW'(MDU_LATENCY - 2);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ld_use, pc_w, ifid_w, idex_w, bubble, flush;
  assign ld_use = h.i_idex_MemRead && (h.i_idex_rt != 5'd0) &&
                  ((h.i_idex_rt == h.i_ifid_rs) || (h.i_ifid_uses_rt && (h.i_idex_rt == h.i_ifid_rt)));
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = RUN;
    cnt_n = cnt;
    pc_w = 1'b1;
    ifid_w = 1'b1;
    idex_w = 1'b1;
    bubble = 1'b0;
    flush = 1'b0;
    if (state == MDU_WAIT) begin
      pc_w = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
      cnt_n = cnt - CW'(1);
      state_n = (cnt == CW'(1)) ? RUN : MDU_WAIT;
    end else if (h.i_branch_taken) begin
      flush = 1'b1;
      bubble = 1'b1;
    end else if (h.i_mdu_start) begin
      pc_w = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
      cnt_n = MDU_INIT;
      state_n = (MDU_LATENCY == 2) ? RUN : MDU_WAIT;
    end else if (ld_use) begin
      pc_w = 1'b0;
      ifid_w = 1'b0;
      bubble = 1'b1;
      state_n = LOAD_STALL;
    end
  end
  // reset overrides every input so the front end keeps fetching cleanly
  assign h.o_PCWrite = i_rst | pc_w;
  assign h.o_IFIDWrite = i_rst | ifid_w;
  assign h.o_IDEXWrite = i_rst | idex_w;
  assign h.o_IDEX_bubble = !i_rst && bubble;
  assign h.o_IFID_flush = !i_rst && flush;
  assign h.o_state = i_rst ? 2'd0 : state;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_w && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 16'd1;
    end
  assign h.o_stall_cycles = stall_cycles;
  assign h.o_flush_count = flush_count;
`endif
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb_id_ex_hazard_ctrl: directed vectors for the hazard controller at MDU_LATENCY 4 and 2
module tb_id_ex_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  id_ex_hazard_ctrl_if a ();
  id_ex_hazard_ctrl_if b ();
  id_ex_hazard_ctrl #(.MDU_LATENCY(4)) dut_a (.i_clk(clk), .i_rst(rst), .h(a.slave));
  id_ex_hazard_ctrl #(.MDU_LATENCY(2)) dut_b (.i_clk(clk), .i_rst(rst), .h(b.slave));
  assign b.i_ifid_rs = a.i_ifid_rs;
  assign b.i_ifid_rt = a.i_ifid_rt;
  assign b.i_idex_rt = a.i_idex_rt;
  assign b.i_ifid_uses_rt = a.i_ifid_uses_rt;
  assign b.i_idex_MemRead = a.i_idex_MemRead;
  assign b.i_mdu_start = a.i_mdu_start;
  assign b.i_branch_taken = a.i_branch_taken;
  // packed as {PCWrite, IFIDWrite, IDEXWrite, bubble, flush, state[1:0]}
  function automatic logic [6:0] oa();
    return {a.o_PCWrite, a.o_IFIDWrite, a.o_IDEXWrite, a.o_IDEX_bubble, a.o_IFID_flush, a.o_state};
  endfunction
  function automatic logic [6:0] ob();
    return {b.o_PCWrite, b.o_IFIDWrite, b.o_IDEXWrite, b.o_IDEX_bubble, b.o_IFID_flush, b.o_state};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mdu, input logic br);
    a.i_idex_MemRead = mr;
    a.i_idex_rt = xrt;
    a.i_ifid_rs = rs;
    a.i_ifid_rt = rt;
    a.i_ifid_uses_rt = urt;
    a.i_mdu_start = mdu;
    a.i_branch_taken = br;
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("rst_c0", 32'(oa()), 32'h70);
    tick;
    chk("rst_c1", 32'(oa()), 32'h70);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("rst_after", 32'(oa()), 32'h70);
    drive(1, 5, 5, 0, 0, 0, 0);
    chk("lu_stall", 32'(oa()), 32'h18);
    tick;
    drive(0, 5, 5, 0, 0, 0, 0);
    chk("lu_next", 32'(oa()), 32'h71);
    tick;
    chk("lu_run", 32'(oa()), 32'h70);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("nh_r0", 32'(oa()), 32'h70);
    drive(1, 7, 3, 7, 0, 0, 0);
    chk("nh_nort", 32'(oa()), 32'h70);
    drive(1, 7, 3, 7, 1, 0, 0);
    chk("lu_rt", 32'(oa()), 32'h18);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("mdu4_c0", 32'(oa()), 32'h00);
    chk("mdu2_c0", 32'(ob()), 32'h00);
    tick;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mdu4_c1_nobr", 32'(oa()), 32'h02);
    chk("mdu2_c1_br", 32'(ob()), 32'h7C);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mdu4_c2", 32'(oa()), 32'h02);
    chk("mdu2_c2", 32'(ob()), 32'h70);
    tick;
    chk("mdu4_c3", 32'(oa()), 32'h70);
    drive(1, 5, 5, 0, 0, 1, 1);
    chk("coll", 32'(oa()), 32'h7C);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("coll_next", 32'(oa()), 32'h70);
    drive(0, 0, 0, 0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mid_wait", 32'(oa()), 32'h02);
    rst = 1'b1;
    #1;
    chk("mid_rst", 32'(oa()), 32'h70);
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rel", 32'(oa()), 32'h70);
    tick;
    chk("mid_run", 32'(oa()), 32'h70);
`ifdef HAZ_STALL_CNT_EN
    rst = 1'b1;
    #1;
    chk("cnt_rst_s", a.o_stall_cycles, 32'd0);
    tick;
    rst = 1'b0;
    drive(1, 5, 5, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    drive(1, 5, 5, 0, 0, 1, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("cnt_stall", a.o_stall_cycles, 32'd1);
    chk("cnt_flush", 32'(a.o_flush_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("cnt_rst_s2", a.o_stall_cycles, 32'd0);
    chk("cnt_rst_f2", 32'(a.o_flush_count), 32'd0);
    tick;
    rst = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
